// File: rtl/umi_merge_arbiter_pkg.sv
// Shared UMI defaults for the merge arbiter slice.
// Latency: n/a (constants only).
// Backpressure: n/a.
// Contents: default address and packet widths used as parameter defaults.
package umi_merge_arbiter_pkg;

  localparam int UMI_AW = 64;
  localparam int UMI_UW = 256;

endpackage

// File: rtl/umi_merge_arbiter_regslice.sv
// One-entry valid/ready output register (forward-registered slice).
// Latency: 1 cycle from in transfer to out_valid.
// Backpressure: in_ready = nreset & (~out_valid | out_ready); a full, stalled entry blocks input.
// Ports: clk, nreset (sync, active-low); in_valid/in_packet/in_ready; out_valid/out_packet/out_ready.
module umi_merge_arbiter_regslice
  import umi_merge_arbiter_pkg::*;
#(
  parameter int UW = UMI_UW
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          in_valid,
  input  logic [UW-1:0] in_packet,
  output logic          in_ready,
  output logic          out_valid,
  output logic [UW-1:0] out_packet,
  input  logic          out_ready
);

  logic load;

  // The entry can take a new beat when empty or when it drains this cycle.
  assign load     = ~out_valid | out_ready;
  assign in_ready = nreset & load;

  always_ff @(posedge clk) begin
    if (!nreset) begin
      out_valid  <= 1'b0;
      out_packet <= '0;
    end else if (load) begin
      out_valid <= in_valid;
      // Packet holds when the entry empties so the bus does not toggle needlessly.
      if (in_valid) begin
        out_packet <= in_packet;
      end
    end
  end

endmodule

// File: rtl/umi_merge_arbiter.sv
// Two-input UMI merger: umi0 fixed priority, umi1 guaranteed a grant after STARVE umi0 wins.
// Latency: 1 cycle (registered output via regslice).
// Backpressure: input readies are zero whenever the output register is full and stalled.
// Ports: clk, nreset (sync, active-low); umi0_in_*, umi1_in_* (valid/packet/ready); umi_out_* (valid/packet/ready).
module umi_merge_arbiter
  import umi_merge_arbiter_pkg::*;
#(
  parameter int AW     = UMI_AW,
  parameter int UW     = UMI_UW,
  parameter int STARVE = 8
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          umi0_in_valid,
  input  logic [UW-1:0] umi0_in_packet,
  output logic          umi0_in_ready,
  input  logic          umi1_in_valid,
  input  logic [UW-1:0] umi1_in_packet,
  output logic          umi1_in_ready,
  output logic          umi_out_valid,
  output logic [UW-1:0] umi_out_packet,
  input  logic          umi_out_ready
);

  localparam int            CW      = $clog2(STARVE + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE);

  if (AW < 1 || STARVE < 1 || STARVE > 255) begin : g_bad_param
    $error("umi_merge_arbiter: AW must be >= 1 and STARVE in 1..255");
  end

  logic [CW-1:0] starve_cnt;
  logic          slice_ready;
  logic          grant0;
  logic          grant1;
  logic          force1;
  logic          xfer0;
  logic          xfer1;
  logic [UW-1:0] sel_packet;

  // FORCE state: umi1 has waited through STARVE umi0 grants.
  assign force1 = (starve_cnt == CNT_MAX);

  always_comb begin
    grant1     = umi1_in_valid & (force1 | ~umi0_in_valid);
    grant0     = umi0_in_valid & ~grant1;
    sel_packet = grant1 ? umi1_in_packet : umi0_in_packet;
  end

  // slice_ready already carries nreset & load.
  assign umi0_in_ready = slice_ready & grant0;
  assign umi1_in_ready = slice_ready & grant1;

  assign xfer0 = umi0_in_valid & umi0_in_ready;
  assign xfer1 = umi1_in_valid & umi1_in_ready;

  always_ff @(posedge clk) begin
    if (!nreset) begin
      starve_cnt <= '0;
    end else if (xfer1 || !umi1_in_valid) begin
      starve_cnt <= '0;
    end else if (xfer0 && !force1) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  umi_merge_arbiter_regslice #(
    .UW (UW)
  ) u_regslice (
    .clk        (clk),
    .nreset     (nreset),
    .in_valid   (grant0 | grant1),
    .in_packet  (sel_packet),
    .in_ready   (slice_ready),
    .out_valid  (umi_out_valid),
    .out_packet (umi_out_packet),
    .out_ready  (umi_out_ready)
  );

endmodule

// File: tb/tb_umi_merge_arbiter.sv
module tb_umi_merge_arbiter;

  localparam int UW = 32;

  logic          clk;
  logic          nreset;
  logic          u0v, u1v, ordy;
  logic [UW-1:0] u0p, u1p;
  logic          r0, r1, ov;
  logic [UW-1:0] op;

  int n_cmp  = 0;
  int n_fail = 0;

  umi_merge_arbiter #(.AW(64), .UW(UW), .STARVE(8)) dut (
    .clk            (clk),
    .nreset         (nreset),
    .umi0_in_valid  (u0v),
    .umi0_in_packet (u0p),
    .umi0_in_ready  (r0),
    .umi1_in_valid  (u1v),
    .umi1_in_packet (u1p),
    .umi1_in_ready  (r1),
    .umi_out_valid  (ov),
    .umi_out_packet (op),
    .umi_out_ready  (ordy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached, act=running req=finished");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic          u0v;
    logic [UW-1:0] u0p;
    logic          u1v;
    logic [UW-1:0] u1p;
    logic          ordy;
    logic          e_r0;
    logic          e_r1;
    logic          e_ov;
    logic [UW-1:0] e_op;
    logic [3:0]    e_cnt;
  } vec_t;

  vec_t vt [12];

  task automatic chk(input string name, input logic [UW-1:0] act, input logic [UW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: act=%h req=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    nreset = 1'b0;
    u0v = 1'b0; u1v = 1'b0; ordy = 1'b1;
    tick();
    nreset = 1'b1;
  endtask

  initial begin
    int i0, j1;
    logic e1;

    // ---- Reset held 3 cycles with both inputs valid
    nreset = 1'b0;
    u0v = 1'b1; u0p = 32'hA0; u1v = 1'b1; u1p = 32'hB0; ordy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("rst_r0", {31'd0, r0}, 32'd0);
      chk("rst_r1", {31'd0, r1}, 32'd0);
      tick();
      chk("rst_ov", {31'd0, ov}, 32'd0);
      chk("rst_op", op, 32'd0);
      chk("rst_cnt", {28'd0, dut.starve_cnt}, 32'd0);
    end
    nreset = 1'b1;
    #1;
    chk("rel_r0", {31'd0, r0}, 32'd1);
    chk("rel_r1", {31'd0, r1}, 32'd0);
    tick();
    chk("rel_ov", {31'd0, ov}, 32'd1);
    chk("rel_op", op, 32'hA0);

    // ---- Table-driven vectors, starting from a clean reset
    //            u0v   u0p    u1v   u1p    ordy  r0    r1    ov    op     cnt
    vt[0]  = '{1'b1, 32'hA0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b1, 32'hA0, 4'd0};
    vt[1]  = '{1'b1, 32'hA1, 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b1, 32'hA1, 4'd0};
    vt[2]  = '{1'b0, 32'h0,  1'b1, 32'hB0, 1'b1, 1'b0, 1'b1, 1'b1, 32'hB0, 4'd0};
    vt[3]  = '{1'b0, 32'h0,  1'b1, 32'hB1, 1'b1, 1'b0, 1'b1, 1'b1, 32'hB1, 4'd0};
    vt[4]  = '{1'b1, 32'hA2, 1'b1, 32'hB2, 1'b1, 1'b1, 1'b0, 1'b1, 32'hA2, 4'd1};
    vt[5]  = '{1'b1, 32'hA3, 1'b1, 32'hB2, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA2, 4'd1};
    vt[6]  = '{1'b1, 32'hA3, 1'b1, 32'hB2, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA2, 4'd1};
    vt[7]  = '{1'b1, 32'hA3, 1'b1, 32'hB2, 1'b1, 1'b1, 1'b0, 1'b1, 32'hA3, 4'd2};
    vt[8]  = '{1'b1, 32'hA4, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b1, 32'hA3, 4'd0};
    vt[9]  = '{1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 32'hA3, 4'd0};
    vt[10] = '{1'b0, 32'h0,  1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 32'hA3, 4'd0};
    vt[11] = '{1'b1, 32'hA5, 1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 1'b1, 32'hA5, 4'd0};

    do_reset();
    for (int v = 0; v < 12; v++) begin
      u0v = vt[v].u0v; u0p = vt[v].u0p;
      u1v = vt[v].u1v; u1p = vt[v].u1p;
      ordy = vt[v].ordy;
      #1;
      chk($sformatf("vec%0d_r0", v), {31'd0, r0}, {31'd0, vt[v].e_r0});
      chk($sformatf("vec%0d_r1", v), {31'd0, r1}, {31'd0, vt[v].e_r1});
      tick();
      chk($sformatf("vec%0d_ov", v), {31'd0, ov}, {31'd0, vt[v].e_ov});
      chk($sformatf("vec%0d_op", v), op, vt[v].e_op);
      chk($sformatf("vec%0d_cnt", v), {28'd0, dut.starve_cnt}, {28'd0, vt[v].e_cnt});
    end

    // ---- umi0 only stream A0..A9, one beat per cycle, latency 1
    do_reset();
    u1v = 1'b0; ordy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      u0v = 1'b1; u0p = 32'hA0 + i;
      #1;
      chk("s0_r0", {31'd0, r0}, 32'd1);
      tick();
      chk("s0_ov", {31'd0, ov}, 32'd1);
      chk("s0_op", op, 32'hA0 + i);
    end
    u0v = 1'b0;

    // ---- Both valid continuously: 8 x umi0 then 1 x umi1, repeating
    do_reset();
    i0 = 0; j1 = 0; ordy = 1'b1;
    for (int k = 0; k < 27; k++) begin
      u0v = 1'b1; u0p = 32'h100 + i0;
      u1v = 1'b1; u1p = 32'h200 + j1;
      e1 = ((k % 9) == 8);
      #1;
      chk("stv_r0", {31'd0, r0}, {31'd0, ~e1});
      chk("stv_r1", {31'd0, r1}, {31'd0, e1});
      tick();
      chk("stv_op", op, e1 ? (32'h200 + j1) : (32'h100 + i0));
      chk("stv_cnt", {28'd0, dut.starve_cnt}, e1 ? 32'd0 : (k % 9) + 1);
      if (e1) j1++; else i0++;
    end

    // ---- umi1 alone is accepted every cycle; then umi0 takes the next grant
    do_reset();
    u0v = 1'b0; u1v = 1'b1; ordy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      u1p = 32'h300 + k;
      #1;
      chk("u1_r1", {31'd0, r1}, 32'd1);
      tick();
      chk("u1_op", op, 32'h300 + k);
      chk("u1_cnt", {28'd0, dut.starve_cnt}, 32'd0);
    end
    u0v = 1'b1; u0p = 32'h400; u1p = 32'h304;
    #1;
    chk("u1u0_r0", {31'd0, r0}, 32'd1);
    chk("u1u0_r1", {31'd0, r1}, 32'd0);
    tick();
    chk("u1u0_op", op, 32'h400);
    chk("u1u0_cnt", {28'd0, dut.starve_cnt}, 32'd1);

    // ---- Backpressure mid-stream for 5 cycles
    do_reset();
    i0 = 0; ordy = 1'b1;
    u1v = 1'b1; u1p = 32'h600;
    for (int k = 0; k < 3; k++) begin
      u0v = 1'b1; u0p = 32'h500 + i0;
      tick();
      chk("bp_pre_op", op, 32'h500 + i0);
      i0++;
    end
    u0p = 32'h500 + i0;
    ordy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_r0", {31'd0, r0}, 32'd0);
      chk("bp_r1", {31'd0, r1}, 32'd0);
      tick();
      chk("bp_ov", {31'd0, ov}, 32'd1);
      chk("bp_op", op, 32'h502);
      chk("bp_cnt", {28'd0, dut.starve_cnt}, 32'd3);
    end
    ordy = 1'b1;
    #1;
    chk("bp_res_r0", {31'd0, r0}, 32'd1);
    tick();
    chk("bp_res_op", op, 32'h503);
    chk("bp_res_cnt", {28'd0, dut.starve_cnt}, 32'd4);

    // ---- Reset while a packet sits stalled in the output register
    u0v = 1'b0; u1v = 1'b0; ordy = 1'b0;
    tick();
    chk("rm_hold_ov", {31'd0, ov}, 32'd1);
    chk("rm_hold_op", op, 32'h503);
    nreset = 1'b0;
    tick();
    chk("rm_ov", {31'd0, ov}, 32'd0);
    chk("rm_op", op, 32'd0);
    nreset = 1'b1; ordy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rm_post_ov", {31'd0, ov}, 32'd0);
      chk("rm_post_op", op, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
